// File: rtl/riscv_pkg.sv
// Shared front-end definitions: branch-control FSM states, default PC width
// and the 2-bit saturating counter step used by the predictor table.
package riscv_pkg;

  localparam int DEF_DATAWIDTH = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } bc_state_e;

  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    else       return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/branch_ctrl_bht.sv
// Branch history table: one 2-bit saturating counter per entry, one
// combinational lookup port and one registered update port.
module bht
  import riscv_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lkp_idx,
  output logic             lkp_taken,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [ENTRIES-1:0][1:0] ctr_q;

  // Lookup reads the registered table, so a same-cycle update is not visible yet.
  assign lkp_taken = ctr_q[lkp_idx][1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < ENTRIES; e++) ctr_q[e] <= 2'b01;
    end else if (upd_en) begin
      ctr_q[upd_idx] <= ctr_step(ctr_q[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution control: trains the predictor, and on a mispredict
// flushes younger stages for FLUSH_CYCLES then hands fetch a redirect PC.
module branch_ctrl
  import riscv_pkg::*;
#(
  parameter int DATAWIDTH    = DEF_DATAWIDTH,
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [DATAWIDTH-1:0] res_pc,
  input  logic                 res_is_taken,
  input  logic [DATAWIDTH-1:0] res_target,
  input  logic                 res_pred_taken,
  input  logic [DATAWIDTH-1:0] fetch_pc,
  output logic                 pred_taken,
  output logic                 flush,
  output logic                 redir_valid,
  input  logic                 redir_ready,
  output logic [DATAWIDTH-1:0] redir_pc,
  output logic [15:0]          mispredict_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int FCW   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);

  bc_state_e            state_q, state_d;
  logic [FCW-1:0]       fcnt_q, fcnt_d;
  logic [DATAWIDTH-1:0] redir_pc_q;
  logic [15:0]          mcnt_q;
  logic                 accept, mispredict;

  // Only the low PC bits index the table.
  logic unused_pc_hi;
  assign unused_pc_hi = ^{fetch_pc[DATAWIDTH-1:IDX_W], res_pc[DATAWIDTH-1:IDX_W]};

  assign accept     = res_valid & res_ready;
  assign mispredict = accept & (res_is_taken != res_pred_taken);

  bht #(.ENTRIES(BHT_ENTRIES), .IDX_W(IDX_W)) u_bht (
    .clk       (clk),
    .rst       (rst),
    .lkp_idx   (fetch_pc[IDX_W-1:0]),
    .lkp_taken (pred_taken),
    .upd_en    (accept),
    .upd_idx   (res_pc[IDX_W-1:0]),
    .upd_taken (res_is_taken)
  );

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    res_ready   = 1'b0;
    flush       = 1'b0;
    redir_valid = 1'b0;
    case (state_q)
      IDLE: begin
        res_ready = 1'b1;
        if (mispredict) state_d = FLUSH;
      end
      FLUSH: begin
        flush = 1'b1;
        if (fcnt_q == FLUSH_LAST) begin
          fcnt_d  = '0;
          state_d = REDIRECT;
        end else begin
          fcnt_d = fcnt_q + FCW'(1);
        end
      end
      REDIRECT: begin
        redir_valid = 1'b1;
        if (redir_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fcnt_q     <= '0;
      redir_pc_q <= '0;
      mcnt_q     <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (mispredict) begin
        redir_pc_q <= res_is_taken ? res_target : res_pc + DATAWIDTH'(1);
        if (mcnt_q != 16'hFFFF) mcnt_q <= mcnt_q + 16'd1;
      end
    end
  end

  assign redir_pc       = redir_pc_q;
  assign mispredict_cnt = mcnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: predictor training, mispredict flush and
// redirect handshake, PC wrap, counter saturation and mid-flush reset.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid, res_ready;
  logic [31:0] res_pc, res_target, fetch_pc, redir_pc;
  logic        res_is_taken, res_pred_taken, pred_taken;
  logic        flush, redir_valid, redir_ready;
  logic [15:0] mispredict_cnt;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.DATAWIDTH(32), .BHT_ENTRIES(16), .FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_pc         (res_pc),
    .res_is_taken   (res_is_taken),
    .res_target     (res_target),
    .res_pred_taken (res_pred_taken),
    .fetch_pc       (fetch_pc),
    .pred_taken     (pred_taken),
    .flush          (flush),
    .redir_valid    (redir_valid),
    .redir_ready    (redir_ready),
    .redir_pc       (redir_pc),
    .mispredict_cnt (mispredict_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic pr);
    res_valid = 1'b1; res_pc = pc; res_is_taken = tk; res_target = tgt; res_pred_taken = pr;
  endtask

  initial begin
    rst = 1'b1; res_valid = 1'b0; res_pc = '0; res_is_taken = 1'b0; res_target = '0;
    res_pred_taken = 1'b0; fetch_pc = 32'd5; redir_ready = 1'b0;
    #12;
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_redir_valid", {31'd0, redir_valid}, 32'd0);
    chk("rst_redir_pc", redir_pc, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_pred_pc5", {31'd0, pred_taken}, 32'd0);
    chk("idle_mcnt", {16'd0, mispredict_cnt}, 32'd0);
    chk("idle_res_ready", {31'd0, res_ready}, 32'd1);

    // Correct prediction trains counter[8] 01->10; lookup same cycle sees old value.
    fetch_pc = 32'd8;
    resolve(32'd8, 1'b1, 32'd20, 1'b1);
    #1 chk("same_cycle_pre_update", {31'd0, pred_taken}, 32'd0);
    tick();
    res_valid = 1'b0;
    chk("hit_no_flush", {31'd0, flush}, 32'd0);
    chk("hit_no_redir", {31'd0, redir_valid}, 32'd0);
    chk("hit_pred8", {31'd0, pred_taken}, 32'd1);

    // Mispredict: taken, predicted not-taken -> redirect to 20.
    resolve(32'd8, 1'b1, 32'd20, 1'b0);
    tick();
    res_valid = 1'b0;
    chk("mp_flush_c1", {31'd0, flush}, 32'd1);
    chk("mp_valid_c1", {31'd0, redir_valid}, 32'd0);
    chk("mp_ready_c1", {31'd0, res_ready}, 32'd0);
    tick();
    chk("mp_flush_c2", {31'd0, flush}, 32'd1);
    tick();
    chk("mp_flush_done", {31'd0, flush}, 32'd0);
    chk("mp_redir_valid1", {31'd0, redir_valid}, 32'd1);
    chk("mp_redir_pc1", redir_pc, 32'd20);
    chk("mp_mcnt", {16'd0, mispredict_cnt}, 32'd1);
    // Resolution offered during REDIRECT must be ignored.
    resolve(32'd3, 1'b1, 32'd50, 1'b0);
    #1 chk("redir_res_ready", {31'd0, res_ready}, 32'd0);
    tick();
    chk("mp_redir_valid2", {31'd0, redir_valid}, 32'd1);
    chk("mp_redir_pc2", redir_pc, 32'd20);
    tick();
    chk("mp_redir_valid3", {31'd0, redir_valid}, 32'd1);
    chk("mp_redir_pc3", redir_pc, 32'd20);
    res_valid = 1'b0; redir_ready = 1'b1;
    tick();
    redir_ready = 1'b0;
    chk("xfer_idle_valid", {31'd0, redir_valid}, 32'd0);
    chk("xfer_idle_ready", {31'd0, res_ready}, 32'd1);
    chk("redir_ignored_mcnt", {16'd0, mispredict_cnt}, 32'd1);
    fetch_pc = 32'd3;
    #1 chk("redir_ignored_ctr3", {31'd0, pred_taken}, 32'd0);
    fetch_pc = 32'd8;
    #1 chk("ctr8_sat_taken", {31'd0, pred_taken}, 32'd1);

    // Not-taken at max PC, predicted taken -> fall-through wraps to 0.
    resolve(32'hFFFF_FFFF, 1'b0, 32'd77, 1'b1);
    tick();
    res_valid = 1'b0;
    tick();
    tick();
    chk("wrap_redir_valid", {31'd0, redir_valid}, 32'd1);
    chk("wrap_redir_pc", redir_pc, 32'd0);
    redir_ready = 1'b1;
    tick();
    redir_ready = 1'b0;
    chk("wrap_mcnt", {16'd0, mispredict_cnt}, 32'd2);
    chk("wrap_idle_ready", {31'd0, res_ready}, 32'd1);

    // Index 15 now 00: one more not-taken holds 00, then taken -> 01 (pred 0).
    resolve(32'd15, 1'b0, 32'd0, 1'b0);
    tick();
    resolve(32'd15, 1'b1, 32'd0, 1'b1);
    tick();
    res_valid = 1'b0;
    fetch_pc = 32'd15;
    #1 chk("ctr15_sat_low", {31'd0, pred_taken}, 32'd0);

    // Four taken updates to index 3 saturate at 11; two decrements -> 10 then 01.
    for (int i = 0; i < 4; i++) begin
      resolve(32'd3, 1'b1, 32'd40, 1'b1);
      tick();
    end
    res_valid = 1'b0;
    fetch_pc = 32'd3;
    #1 chk("ctr3_after4", {31'd0, pred_taken}, 32'd1);
    resolve(32'd3, 1'b0, 32'd0, 1'b0);
    tick();
    res_valid = 1'b0;
    #1 chk("ctr3_dec1", {31'd0, pred_taken}, 32'd1);
    resolve(32'd3, 1'b0, 32'd0, 1'b0);
    tick();
    res_valid = 1'b0;
    #1 chk("ctr3_dec2", {31'd0, pred_taken}, 32'd0);
    chk("no_mp_mcnt", {16'd0, mispredict_cnt}, 32'd2);

    // Reset mid-FLUSH clears everything asynchronously.
    fetch_pc = 32'd8;
    resolve(32'd4, 1'b1, 32'd100, 1'b0);
    tick();
    res_valid = 1'b0;
    chk("pre_rst_flush", {31'd0, flush}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_flush", {31'd0, flush}, 32'd0);
    chk("async_rst_valid", {31'd0, redir_valid}, 32'd0);
    chk("async_rst_pc", redir_pc, 32'd0);
    chk("async_rst_mcnt", {16'd0, mispredict_cnt}, 32'd0);
    chk("async_rst_ctr8", {31'd0, pred_taken}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("post_rst_flush", {31'd0, flush}, 32'd0);
    chk("post_rst_valid", {31'd0, redir_valid}, 32'd0);
    chk("post_rst_ready", {31'd0, res_ready}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
